// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit and the controller that drives MDUctr.
package mult_div_unit_pkg;

   // Operation select encodings carried on MDUctr (7-15 behave as none)
   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MTHI  = 4'd5,
      MDU_MTLO  = 4'd6
   } mdu_op_e;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } mdu_state_e;

   // Default latencies, start edge to HI/LO commit
   localparam int unsigned MDU_DEF_MULT_CYCLES = 5;
   localparam int unsigned MDU_DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are formed combinationally from the latched operands; a down-counter
// only delays the commit so the pipeline sees a fixed latency per operation.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MDU_DEF_MULT_CYCLES,
   parameter int unsigned DIV_CYCLES  = MDU_DEF_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [3:0]  MDUctr,
   input  logic        start,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

   mdu_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_a;
   logic [31:0]      r_b;
   logic [3:0]       r_op;
   logic             r_busy;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;

   logic [63:0]        w_prod_u;
   logic signed [63:0] w_prod_s;
   logic [63:0]        w_prod;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [31:0]        w_b_safe;
   logic [31:0]        w_a_mag;
   logic [31:0]        w_b_mag;
   logic [31:0]        w_uq_mag;
   logic [31:0]        w_ur_mag;
   logic [31:0]        w_uq;
   logic [31:0]        w_ur;
   logic [31:0]        w_sq;
   logic [31:0]        w_sr;
   logic [31:0]        w_quot;
   logic [31:0]        w_rem;

   // Products: both operands widened to 64 bits so the signed form sign-extends
   assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
   assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
   assign w_prod   = (r_op == MDU_MULTU) ? w_prod_u : w_prod_s;

   // Division through magnitudes; avoids the signed-overflow corner of
   // 0x80000000 / -1 and never divides by zero (the commit is skipped then)
   assign w_b_safe = (r_b == 32'd0) ? 32'd1 : r_b;
   assign w_a_neg  = r_a[31];
   assign w_b_neg  = w_b_safe[31];
   assign w_a_mag  = w_a_neg ? (32'd0 - r_a) : r_a;
   assign w_b_mag  = w_b_neg ? (32'd0 - w_b_safe) : w_b_safe;
   assign w_uq_mag = w_a_mag / w_b_mag;
   assign w_ur_mag = w_a_mag % w_b_mag;
   assign w_sq     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq_mag) : w_uq_mag;
   assign w_sr     = w_a_neg ? (32'd0 - w_ur_mag) : w_ur_mag;
   assign w_uq     = r_a / w_b_safe;
   assign w_ur     = r_a % w_b_safe;
   assign w_quot   = (r_op == MDU_DIVU) ? w_uq : w_sq;
   assign w_rem    = (r_op == MDU_DIVU) ? w_ur : w_sr;

   // Sequencer: accept ops in IDLE, count down, commit HI/LO as busy drops
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_busy  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (MDUctr == MDU_MULT || MDUctr == MDU_MULTU) begin
                     r_a     <= A;
                     r_b     <= B;
                     r_op    <= MDUctr;
                     r_cnt   <= MUL_LOAD;
                     r_state <= ST_MUL;
                     r_busy  <= 1'b1;
                  end else if (MDUctr == MDU_DIV || MDUctr == MDU_DIVU) begin
                     r_a     <= A;
                     r_b     <= B;
                     r_op    <= MDUctr;
                     r_cnt   <= DIV_LOAD;
                     r_state <= ST_DIV;
                     r_busy  <= 1'b1;
                  end else if (MDUctr == MDU_MTHI) begin
                     r_hi <= A;
                  end else if (MDUctr == MDU_MTLO) begin
                     r_lo <= A;
                  end
               end
            end
            ST_MUL: begin
               if (r_cnt == '0) begin
                  r_hi    <= w_prod[63:32];
                  r_lo    <= w_prod[31:0];
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_DIV: begin
               if (r_cnt == '0) begin
                  // A zero divisor still occupies the unit but leaves HI/LO alone
                  if (r_b != 32'd0) begin
                     r_hi <= w_rem;
                     r_lo <= w_quot;
                  end
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   logic        clk;
   logic        reset;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  MDUctr;
   logic        start;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_checks;
   int n_fails;
   int n_cyc;

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk    (clk),
      .reset  (reset),
      .A      (A),
      .B      (B),
      .MDUctr (MDUctr),
      .start  (start),
      .busy   (busy),
      .HI     (HI),
      .LO     (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge: presents a start for the next rising edge,
   // then scrambles the operands to show they were latched.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      $display("issue op=%0d A=0x%08h B=0x%08h", op, a, b);
      A = a; B = b; MDUctr = op; start = 1'b1;
      @(negedge clk);
      start = 1'b0; MDUctr = 4'd0;
      A = $urandom; B = $urandom;
   endtask

   // Counts falling edges with busy high; bounded so a stuck busy fails the cycle check
   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 50) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      n_checks = 0; n_fails = 0;
      A = '0; B = '0; MDUctr = '0; start = 1'b0;
      reset = 1'b0;
      #1;
      check_eq("reset_hi", HI, 32'h0);
      check_eq("reset_lo", LO, 32'h0);
      check_eq("reset_busy", {31'd0, busy}, 32'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // mult -1 * 2
      issue(MDU_MULT, 32'hFFFFFFFF, 32'd2);
      wait_idle(n_cyc);
      check_eq("mult_cycles", n_cyc, 32'd5);
      check_eq("mult_hi", HI, 32'hFFFFFFFF);
      check_eq("mult_lo", LO, 32'hFFFFFFFE);

      // multu same operands
      issue(MDU_MULTU, 32'hFFFFFFFF, 32'd2);
      wait_idle(n_cyc);
      check_eq("multu_cycles", n_cyc, 32'd5);
      check_eq("multu_hi", HI, 32'h00000001);
      check_eq("multu_lo", LO, 32'hFFFFFFFE);

      // div -7 / 2
      issue(MDU_DIV, 32'hFFFFFFF9, 32'd2);
      wait_idle(n_cyc);
      check_eq("div_cycles", n_cyc, 32'd10);
      check_eq("div_lo", LO, 32'hFFFFFFFD);
      check_eq("div_hi", HI, 32'hFFFFFFFF);

      // divu by zero leaves HI/LO
      issue(MDU_DIVU, 32'd7, 32'd0);
      check_eq("divz_busy", {31'd0, busy}, 32'd1);
      wait_idle(n_cyc);
      check_eq("divz_cycles", n_cyc, 32'd10);
      check_eq("divz_lo", LO, 32'hFFFFFFFD);
      check_eq("divz_hi", HI, 32'hFFFFFFFF);

      // overflow corner
      issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_idle(n_cyc);
      check_eq("divov_lo", LO, 32'h80000000);
      check_eq("divov_hi", HI, 32'h00000000);

      // divu 100 / 7
      issue(MDU_DIVU, 32'd100, 32'd7);
      wait_idle(n_cyc);
      check_eq("divu_lo", LO, 32'd14);
      check_eq("divu_hi", HI, 32'd2);

      // mthi / mtlo in idle
      issue(MDU_MTHI, 32'h12345678, 32'd0);
      check_eq("mthi_hi", HI, 32'h12345678);
      check_eq("mthi_busy", {31'd0, busy}, 32'd0);
      issue(MDU_MTLO, 32'hCAFEF00D, 32'd0);
      check_eq("mtlo_lo", LO, 32'hCAFEF00D);
      check_eq("mtlo_hi", HI, 32'h12345678);

      // invalid op does nothing
      issue(4'd9, 32'h55555555, 32'd3);
      check_eq("nop_busy", {31'd0, busy}, 32'd0);
      check_eq("nop_hi", HI, 32'h12345678);
      check_eq("nop_lo", LO, 32'hCAFEF00D);

      // mtlo during a mult is ignored
      issue(MDU_MULT, 32'd3, 32'd4);
      $display("issue op=6 A=0xdeadbeef during busy");
      A = 32'hDEADBEEF; MDUctr = MDU_MTLO; start = 1'b1;
      @(negedge clk);
      start = 1'b0; MDUctr = 4'd0;
      wait_idle(n_cyc);
      check_eq("busyig_cycles", n_cyc + 1, 32'd5);
      check_eq("busyig_lo", LO, 32'd12);
      check_eq("busyig_hi", HI, 32'd0);

      // back-to-back: div started on the edge right after busy falls
      issue(MDU_MULT, 32'd6, 32'd7);
      wait_idle(n_cyc);
      check_eq("b2b_mult_lo", LO, 32'd42);
      issue(MDU_DIV, 32'hFFFFFF9C, 32'd7);
      check_eq("b2b_busy", {31'd0, busy}, 32'd1);
      wait_idle(n_cyc);
      check_eq("b2b_cycles", n_cyc, 32'd10);
      check_eq("b2b_div_lo", LO, 32'hFFFFFFF2);
      check_eq("b2b_div_hi", HI, 32'hFFFFFFFE);

      // reset mid-div discards the result
      issue(MDU_DIV, 32'd1000, 32'd3);
      @(negedge clk); @(negedge clk); @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_mid_hi", HI, 32'h0);
      check_eq("rst_mid_lo", LO, 32'h0);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      repeat (15) @(negedge clk);
      check_eq("rst_after_hi", HI, 32'h0);
      check_eq("rst_after_lo", LO, 32'h0);
      check_eq("rst_after_busy", {31'd0, busy}, 32'd0);

      // first start after reset is accepted
      issue(MDU_MULTU, 32'd2, 32'd3);
      wait_idle(n_cyc);
      check_eq("post_rst_cycles", n_cyc, 32'd5);
      check_eq("post_rst_lo", LO, 32'd6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
